// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: PC-source codes, PC-stage state encoding
// and the default datapath width.
package riscv_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;
    localparam logic [1:0] PC_SRC_TRAP   = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// Bundle between the PC stage and its neighbours (next-PC select in, fetch handshake out).
// The unit itself attaches through the slave modport.
interface pc_next_unit_if
    import riscv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
);
    logic [1:0]      pc_src;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jalr_target;
    logic            fetch_ready;
    logic            resume;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fetch_valid;
    logic            misalign;
    logic            halted;

    modport master (
        output pc_src, imm, jalr_target, fetch_ready, resume,
        input  pc, pc_plus4, fetch_valid, misalign, halted
    );

    modport slave (
        input  pc_src, imm, jalr_target, fetch_ready, resume,
        output pc, pc_plus4, fetch_valid, misalign, halted
    );
endinterface

// File: rtl/pc_target_mux.sv
// Combinational next-PC target select with adders and alignment check.
// PC_MISALIGN_TRAP_EN: report misaligned targets instead of silently aligning them.
module pc_target_mux
    import riscv_pkg::*;
#(
    parameter int              XLEN    = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] TRAP_PC = XLEN'(32'h0000_0100)
) (
    input  logic [XLEN-1:0]        pc,
    input  logic [1:0]             pc_src,
    input  logic signed [XLEN-1:0] imm,
    input  logic [XLEN-1:0]        jalr_target,
    output logic [XLEN-1:0]        target,
    output logic [XLEN-1:0]        pc_plus4,
    output logic                   misaligned
);
    logic [XLEN-1:0] raw_target;

    // All sums wrap modulo 2^XLEN; imm is two's complement so a plain add is correct.
    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        raw_target = pc_plus4;
        case (pc_src)
            PC_SRC_PLUS4:  raw_target = pc_plus4;
            PC_SRC_BRANCH: raw_target = pc + $unsigned(imm);
            PC_SRC_JALR:   raw_target = jalr_target & ~XLEN'(1);
            default:       raw_target = TRAP_PC;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    // TRAP_PC is assumed aligned, so the trap path is never flagged.
    assign target     = raw_target;
    assign misaligned = (pc_src != PC_SRC_TRAP) && (raw_target[1:0] != 2'b00);
`else
    assign target     = raw_target & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC register with BOOT/RUN/HALT control and fetch valid/ready handshake.
// PC_MISALIGN_TRAP_EN: misaligned targets halt the stage until a resume pulse.
module pc_next_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst,
    pc_next_unit_if.slave   bus
);
    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic            misaligned;
    logic            fetch_valid;

    pc_target_mux #(
        .XLEN    (XLEN),
        .TRAP_PC (TRAP_PC)
    ) u_target_mux (
        .pc          (pc_q),
        .pc_src      (bus.pc_src),
        .imm         (bus.imm),
        .jalr_target (bus.jalr_target),
        .target      (target),
        .pc_plus4    (pc_plus4),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        misalign_d  = misalign_q;
        fetch_valid = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                fetch_valid = 1'b1;
                if (bus.fetch_ready) begin
                    // A misaligned target keeps the old PC so the offending fetch is visible.
                    if (misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    pc_d       = TRAP_PC;
                    misalign_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = fetch_valid;
    assign bus.misalign    = misalign_q;

`ifdef PC_MISALIGN_TRAP_EN
    assign bus.halted = (state_q == ST_HALT);
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: boot, backpressure, target arithmetic, wrap,
// misalign halt/resume (build-dependent) and asynchronous reset.
module tb_pc_next_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    pc_next_unit_if #(.XLEN(XLEN)) bus ();

    pc_next_unit #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000),
        .TRAP_PC  (32'h0000_0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic accept(input logic [1:0] src, input logic [XLEN-1:0] im, input logic [XLEN-1:0] jt);
        bus.pc_src      = src;
        bus.imm         = im;
        bus.jalr_target = jt;
        bus.fetch_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fetch_ready = 1'b1;
        bus.pc_src = 2'b00;
        repeat (3) step();
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_fv", 32'(bus.fetch_valid), 32'h0);
        chk("reset_misalign", 32'(bus.misalign), 32'h0);
        chk("reset_halted", 32'(bus.halted), 32'h0);
        rst = 1'b0;
        chk("boot_fv", 32'(bus.fetch_valid), 32'h0);
        step();
        chk("run_fv", 32'(bus.fetch_valid), 32'h1);
        chk("run_pc", bus.pc, 32'h0);
        step();
        chk("seq_pc4", bus.pc, 32'h4);
        step();
        chk("seq_pc8", bus.pc, 32'h8);
        step();
        chk("seq_pcC", bus.pc, 32'hC);
    endtask

    task automatic test_backpressure();
        accept(2'b10, '0, 32'h10);
        chk("bp_start_pc", bus.pc, 32'h10);
        bus.fetch_ready = 1'b0;
        bus.pc_src = 2'b01;
        bus.imm = 32'h40;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_pc", bus.pc, 32'h10);
            chk("bp_hold_fv", 32'(bus.fetch_valid), 32'h1);
        end
        bus.fetch_ready = 1'b1;
        step();
        chk("bp_release_pc", bus.pc, 32'h50);
    endtask

    task automatic test_branch_jalr();
        accept(2'b11, '0, '0);
        chk("trap_pc", bus.pc, 32'h100);
        accept(2'b01, 32'hFFFF_FFF0, '0);
        chk("branch_neg_pc", bus.pc, 32'hF0);
        accept(2'b10, '0, 32'h2001);
        chk("jalr_lsb_pc", bus.pc, 32'h2000);
        accept(2'b11, '0, '0);
        chk("trap_again_pc", bus.pc, 32'h100);
    endtask

    task automatic test_wrap();
        accept(2'b10, '0, 32'hFFFF_FFFC);
        chk("wrap_start_pc", bus.pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", bus.pc_plus4, 32'h0);
        accept(2'b00, '0, '0);
        chk("wrap_pc", bus.pc, 32'h0);
    endtask

    task automatic test_resume_ignored();
        bus.fetch_ready = 1'b0;
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        chk("resume_run_pc", bus.pc, 32'h0);
        chk("resume_run_fv", 32'(bus.fetch_valid), 32'h1);
    endtask

    task automatic test_misalign();
        accept(2'b10, '0, 32'h20);
        chk("mis_start_pc", bus.pc, 32'h20);
        accept(2'b01, 32'h6, '0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_hold_pc", bus.pc, 32'h20);
        chk("mis_flag", 32'(bus.misalign), 32'h1);
        chk("mis_halted", 32'(bus.halted), 32'h1);
        chk("mis_fv", 32'(bus.fetch_valid), 32'h0);
        bus.pc_src = 2'b00;
        step();
        step();
        chk("halt_ignore_ready_pc", bus.pc, 32'h20);
        chk("halt_stays", 32'(bus.halted), 32'h1);
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        chk("resume_pc", bus.pc, 32'h100);
        chk("resume_misalign", 32'(bus.misalign), 32'h0);
        chk("resume_halted", 32'(bus.halted), 32'h0);
        chk("resume_fv", 32'(bus.fetch_valid), 32'h1);
`else
        chk("mis_aligned_pc", bus.pc, 32'h24);
        chk("mis_flag_off", 32'(bus.misalign), 32'h0);
        chk("mis_halted_off", 32'(bus.halted), 32'h0);
        chk("mis_fv_on", 32'(bus.fetch_valid), 32'h1);
`endif
    endtask

    task automatic test_async_reset();
        accept(2'b10, '0, 32'h40);
        chk("ar_start_pc", bus.pc, 32'h40);
        bus.pc_src = 2'b00;
        bus.fetch_ready = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("ar_pc_now", bus.pc, 32'h0);
        chk("ar_fv_now", 32'(bus.fetch_valid), 32'h0);
        step();
        rst = 1'b0;
        chk("ar_boot_fv", 32'(bus.fetch_valid), 32'h0);
        step();
        chk("ar_run_pc", bus.pc, 32'h0);
        step();
        chk("ar_run_pc4", bus.pc, 32'h4);
    endtask

    initial begin
        bus.pc_src = 2'b00;
        bus.imm = '0;
        bus.jalr_target = '0;
        bus.fetch_ready = 1'b0;
        bus.resume = 1'b0;
        test_reset();
        test_backpressure();
        test_branch_jalr();
        test_wrap();
        test_resume_ignored();
        test_misalign();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage directly downstream of the 2-bit PC-source combine logic.
- Consumes the 2-bit pc_src code and selects the next PC from PC+4, branch target (PC+imm), JALR target, or the trap vector.
- Holds the architectural PC register and presents it to instruction fetch over a valid/ready handshake.
- Optionally detects misaligned targets and halts until resumed.

Parameters:
- XLEN, 32, datapath/PC width in bits
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_PC, 32'h0000_0100, PC loaded for pc_src=2'b11 and on resume from HALT

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- pc_src  input  2  next-PC select: 00 PC+4, 01 PC+imm, 10 jalr_target, 11 TRAP_PC
- imm  input  XLEN  sign-extended branch/JAL offset
- jalr_target  input  XLEN  rs1+imm from the ALU
- fetch_ready  input  1  fetch accepts current pc
- resume  input  1  leave HALT; single-cycle pulse
- pc  output  XLEN  current PC
- pc_plus4  output  XLEN  pc+4, combinational, wraps mod 2^XLEN
- fetch_valid  output  1  pc is valid for fetch
- misalign  output  1  sticky misaligned-target flag
- halted  output  1  high while in HALT

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset values while rst is high: pc=RESET_PC, fetch_valid=0, misalign=0, halted=0, state=BOOT.
- States:
  - BOOT: one cycle after rst deasserts, fetch_valid=0; then go to RUN.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, halted=1.
- Handshake:
  - PC advances only on a rising edge with fetch_valid & fetch_ready.
  - pc_src, imm and jalr_target are sampled on that edge.
  - If fetch_ready=0, pc and fetch_valid hold; selection inputs are ignored.
- Target computation, all modulo 2^XLEN, no overflow detection:
  - 00: pc+4.
  - 01: pc+imm.
  - 10: {jalr_target[XLEN-1:1],1'b0}.
  - 11: TRAP_PC.
- Latency: the new pc is visible one cycle after the accepting edge. No bubbles in RUN.
- Wrap-around: pc=32'hFFFF_FFFC with src 00 gives 32'h0000_0000.
- Reset mid-operation:
  - Asserting rst in any state immediately forces the reset values.
  - An in-flight handshake is discarded.
- HALT exit:
  - resume=1 in HALT: next edge loads pc=TRAP_PC, clears misalign and halted, and goes to RUN.
  - resume outside HALT is ignored.
  - fetch_ready is ignored in HALT.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN
- Defined:
  - On an accepting edge, if the selected target has target[1:0]!=2'b00, pc holds its old value.
  - misalign is set (sticky) and the state goes to HALT.
  - pc_src=11 is never checked; TRAP_PC must be aligned.
- Undefined:
  - target[1:0] is forced to 2'b00 and no halt occurs.
  - misalign is tied 0, and HALT is reachable only if the macro is defined.
  - halted is then tied 0 and resume is unused.

Decomposition:
- Shared package (riscv_pkg):
  - PC_SRC_* localparams for the 2-bit codes (PC_SRC_PLUS4=2'b00, PC_SRC_BRANCH=2'b01, PC_SRC_JALR=2'b10, PC_SRC_TRAP=2'b11).
  - The state encoding BOOT/RUN/HALT.
  - The default XLEN.
- One natural sub-module: pc_target_mux, a combinational 4-way target select plus adders and the alignment check. The register, FSM and handshake stay in pc_next_unit.

Test Plan:
- Reset and boot: rst high 3 cycles, then low with fetch_ready=1 → pc=0, fetch_valid=0 for 1 cycle, then 1; after 3 accepts with src 00, pc=32'h0000_000C.
- Backpressure: pc=32'h10, fetch_ready=0 for 4 cycles with src=01 and imm=32'h40 → pc stays 32'h10; on the ready cycle the next pc is 32'h50.
- Branch/JALR arithmetic:
  - pc=32'h100, src=01, imm=32'hFFFF_FFF0 → pc=32'hF0.
  - src=10, jalr_target=32'h2001 → pc=32'h2000.
- Trap and wrap:
  - src=11 → pc=32'h100.
  - pc=32'hFFFF_FFFC with src=00 → pc=32'h0.
- Misalign (PC_MISALIGN_TRAP_EN defined): pc=32'h20, src=01, imm=32'h6 → pc holds 32'h20, misalign=1, halted=1, fetch_valid=0; a resume pulse → pc=32'h100, flags cleared, fetch_valid=1. With the macro undefined, the same stimulus gives pc=32'h24.
- Reset mid-run: assert rst asynchronously mid-cycle while in RUN with a pending accept → pc=RESET_PC immediately, before the next clk edge.
